// File: rtl/io_ccff_loader.sv
// IO-tile configuration chain loader: serialises cfg words onto ccff_head.
// Optional CRC readback of the chain is enabled with IO_CCFF_READBACK_EN.
`timescale 1ns/1ps
module io_ccff_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int ISOL_HOLD = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int HW = $clog2(ISOL_HOLD + 1);
  localparam int CW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISOLATE,
    SHIFT,
    SETTLE,
`ifdef IO_CCFF_READBACK_EN
    VERIFY,
`endif
    DONE
  } state_t;

  state_t            state_q, state_n;
  logic [HW-1:0]     hold_q, hold_n;
  logic [BW-1:0]     bit_q, bit_n;
  logic [CW-1:0]     left_q, left_n;
  logic [WORD_W-1:0] wreg_q, wreg_n;
  logic              head_q, head_n;
  logic              conf_q, conf_n;
  logic              clr, new_bit;
  logic [BW-1:0]     rem;
  logic              last_w;

  assign rem      = BW'(CHAIN_LEN) - bit_q;
  assign last_w   = 32'(rem) < WORD_W;
  assign cfg_busy = state_q != IDLE;

`ifdef IO_CCFF_READBACK_EN
  logic [7:0] crc_tx_q, crc_rx_q;
  logic       err_q;
  logic       crc_match;
  logic       ver_last;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign crc_match = crc8(crc_rx_q, ccff_tail) == crc_tx_q;
  assign ver_last  = bit_q == BW'(CHAIN_LEN - 1);
  assign cfg_err   = err_q;
  // Recirculate so the chain holds its contents after the readback pass
  assign ccff_head = (state_q == VERIFY) ? ccff_tail : head_q;
`else
  logic unused_sig;
  assign unused_sig = ^{ccff_tail, clr, new_bit};
  assign cfg_err    = 1'b0;
  assign ccff_head  = head_q;
`endif

  always_comb begin
    state_n   = state_q;
    hold_n    = hold_q;
    bit_n     = bit_q;
    left_n    = left_q;
    wreg_n    = wreg_q;
    head_n    = head_q;
    conf_n    = conf_q;
    clr       = 1'b0;
    new_bit   = 1'b0;
    cfg_ready = 1'b0;
    cfg_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_n = ISOLATE;
          conf_n  = 1'b0;
          clr     = 1'b1;
          hold_n  = '0;
          bit_n   = '0;
          left_n  = '0;
          head_n  = 1'b0;
        end
      end
      ISOLATE: begin
        if (hold_q == HW'(ISOL_HOLD - 1)) begin
          hold_n  = '0;
          state_n = SHIFT;
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end
      SHIFT: begin
        if (bit_q == BW'(CHAIN_LEN)) begin
          state_n = SETTLE;
          head_n  = 1'b0;
          hold_n  = '0;
          bit_n   = '0;
        end else if (left_q != '0) begin
          new_bit = 1'b1;
          head_n  = wreg_q[0];
          wreg_n  = wreg_q >> 1;
          left_n  = left_q - CW'(1);
          bit_n   = bit_q + BW'(1);
        end else begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            new_bit = 1'b1;
            head_n  = cfg_data[0];
            wreg_n  = cfg_data >> 1;
            // Final word only carries the bits still missing from the chain
            left_n  = last_w ? CW'(rem - BW'(1)) : CW'(WORD_W - 1);
            bit_n   = bit_q + BW'(1);
          end
        end
      end
      SETTLE: begin
        if (hold_q == HW'(ISOL_HOLD - 1)) begin
          hold_n = '0;
`ifdef IO_CCFF_READBACK_EN
          state_n = VERIFY;
`else
          state_n = DONE;
`endif
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end
`ifdef IO_CCFF_READBACK_EN
      VERIFY: begin
        bit_n = bit_q + BW'(1);
        if (ver_last) begin
          bit_n   = '0;
          state_n = crc_match ? DONE : IDLE;
        end
      end
`endif
      DONE: begin
        cfg_done = 1'b1;
        conf_n   = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      bit_q     <= '0;
      left_q    <= '0;
      wreg_q    <= '0;
      head_q    <= 1'b0;
      conf_q    <= 1'b0;
      IO_ISOL_N <= 1'b0;
    end else begin
      state_q   <= state_n;
      hold_q    <= hold_n;
      bit_q     <= bit_n;
      left_q    <= left_n;
      wreg_q    <= wreg_n;
      head_q    <= head_n;
      conf_q    <= conf_n;
      IO_ISOL_N <= (state_n == IDLE) && conf_n;
    end
  end

`ifdef IO_CCFF_READBACK_EN
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_tx_q <= '0;
      crc_rx_q <= '0;
      err_q    <= 1'b0;
    end else if (clr) begin
      crc_tx_q <= '0;
      crc_rx_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (new_bit)
        crc_tx_q <= crc8(crc_tx_q, head_n);
      if (state_q == VERIFY)
        crc_rx_q <= crc8(crc_rx_q, ccff_tail);
      if (state_q == VERIFY && ver_last && !crc_match)
        err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_io_ccff_loader.sv
// Directed bench for io_ccff_loader with shift-register chain models.
// Two instances: a 24-bit chain and a 20-bit chain, both 8-bit words.
`timescale 1ns/1ps
module tb_io_ccff_loader;
  localparam int ISOL = 4;
`ifdef IO_CCFF_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic        prog_reset, st24, st20, cfg_valid;
  logic [7:0]  cfg_data;
  logic        rdy24, head24, isol24, busy24, done24, err24;
  logic        rdy20, head20, isol20, busy20, done20, err20;
  logic [23:0] m24 = '0;
  logic [19:0] m20 = '0;
  logic        sel, sh, flip;
  logic        rdy, head, isol, busy, done, err;
  int          tests = 0;
  int          fails = 0;

  io_ccff_loader #(.CHAIN_LEN(24), .WORD_W(8), .ISOL_HOLD(ISOL)) u_dut24 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(st24),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy24),
    .ccff_head(head24), .ccff_tail(m24[0]), .IO_ISOL_N(isol24),
    .cfg_busy(busy24), .cfg_done(done24), .cfg_err(err24)
  );

  io_ccff_loader #(.CHAIN_LEN(20), .WORD_W(8), .ISOL_HOLD(ISOL)) u_dut20 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(st20),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy20),
    .ccff_head(head20), .ccff_tail(m20[0]), .IO_ISOL_N(isol20),
    .cfg_busy(busy20), .cfg_done(done20), .cfg_err(err20)
  );

  assign rdy  = sel ? rdy20  : rdy24;
  assign head = sel ? head20 : head24;
  assign isol = sel ? isol20 : isol24;
  assign busy = sel ? busy20 : busy24;
  assign done = sel ? done20 : done24;
  assign err  = sel ? err20  : err24;

  // Chain model: new bits enter at the MSB, bit 0 is the far end (tail)
  always @(posedge prog_clk) begin
    if (sh && !sel) m24 <= {head24, m24[23:1]};
    if (sh && sel)  m20 <= {head20, m20[19:1]};
    if (flip && !sel) m24[7] <= ~m24[7];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_load(input bit s20, input logic [7:0] w0,
                         input logic [7:0] w1, input logic [7:0] w2,
                         input int stall, input int rst_at,
                         input bit corrupt, input logic [23:0] exp_chain);
    logic [7:0] w[3];
    int L, lastn, idx, pend, got, post, n, done_n, ndone;
    int stall_left, vcyc;
    bit hs, stalling, seen, ok;
    logic last_head;
    w[0] = w0; w[1] = w1; w[2] = w2;
    L = s20 ? 20 : 24;
    lastn = s20 ? 4 : 8;
    vcyc = RB * L;
    ok = !corrupt;
    sel = s20;
    idx = 0; pend = 0; got = 0; post = 0; n = 0;
    done_n = 0; ndone = 0; stall_left = 0;
    stalling = 0; seen = 0; last_head = 1'b0; hs = 0;
    cfg_data = w[0];
    cfg_valid = 1'b1;
    if (s20) st20 = 1'b1;
    else st24 = 1'b1;
    tick;
    st20 = 1'b0;
    st24 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge prog_clk);
      n++;
      sh = 1'b0;
      flip = 1'b0;
      chk("isol_n", isol, seen);
      if (done) begin
        ndone++;
        done_n = n;
        seen = 1;
      end
      if (pend > 0) begin
        sh = 1'b1;
        pend--;
        got++;
        last_head = head;
      end else if (got == L) begin
        post++;
        if (post == 1) begin
          chk("head_settle", head, 0);
          flip = corrupt;
        end
        if (post > ISOL && post <= ISOL + vcyc) sh = 1'b1;
      end
      if (stalling && rdy) begin
        chk("stall_hold", head, last_head);
        stall_left--;
      end
      hs = rdy && cfg_valid;
      if (hs) pend += (idx == 2) ? lastn : 8;
      if (rst_at > 0 && got == rst_at) break;
      if (got == L && post >= ISOL + vcyc + 2) break;
      tick;
      if (hs) begin
        idx++;
        if (idx == 1 && stall > 0) begin
          cfg_valid = 1'b0;
          stalling = 1;
          stall_left = stall;
        end else if (idx < 3) begin
          cfg_data = w[idx];
        end else begin
          cfg_valid = 1'b0;
        end
      end else if (stalling && stall_left == 0) begin
        stalling = 0;
        cfg_valid = 1'b1;
        cfg_data = w[1];
      end
    end
    cfg_valid = 1'b0;
    flip = 1'b0;
    if (rst_at > 0) begin
      chk("bits_before_reset", got, rst_at);
      prog_reset = 1'b1;
      tick;
      sh = 1'b0;
      prog_reset = 1'b0;
      @(negedge prog_clk);
      chk("rst_busy", busy, 0);
      chk("rst_isol", isol, 0);
      chk("rst_head", head, 0);
      chk("rst_ready", rdy, 0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) ndone++;
        @(negedge prog_clk);
      end
      chk("rst_no_done", ndone, 0);
      chk("rst_isol_hold", isol, 0);
    end else begin
      sh = 1'b0;
      chk("bits", got, L);
      chk("done_pulses", ndone, ok);
      chk("busy_end", busy, 0);
      chk("isol_end", isol, ok);
      chk("err_end", err, corrupt);
      if (ok) begin
        chk("done_latency", done_n, 2 * ISOL + 2 + L + vcyc + stall);
        chk("chain", s20 ? {12'b0, m20} : {8'b0, m24}, {8'b0, exp_chain});
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_reset = 1'b1;
    st24 = 1'b0; st20 = 1'b0;
    cfg_valid = 1'b0; cfg_data = 8'h00;
    sel = 1'b0; sh = 1'b0; flip = 1'b0;
    repeat (3) tick;
    prog_reset = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'hFF;
    repeat (10) tick;
    @(negedge prog_clk);
    chk("idle_isol", isol24, 0);
    chk("idle_busy", busy24, 0);
    chk("idle_head", head24, 0);
    chk("idle_ready", rdy24, 0);
    chk("idle_done", done24, 0);
    chk("idle_err", err24, 0);
    chk("idle_isol20", isol20, 0);
    cfg_valid = 1'b0;

    do_load(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 0, 24'hF03CA5);
    do_load(1, 8'h5A, 8'hC3, 8'hFF, 0, 0, 0, 24'h0FC35A);
    do_load(0, 8'h11, 8'h22, 8'h33, 0, 10, 0, 24'h000000);
    do_load(0, 8'h12, 8'h34, 8'h56, 0, 0, 0, 24'h563412);
    do_load(0, 8'hA5, 8'h3C, 8'hF0, 5, 0, 0, 24'hF03CA5);
`ifdef IO_CCFF_READBACK_EN
    do_load(0, 8'hA5, 8'h3C, 8'hF0, 0, 0, 1, 24'h000000);
    do_load(0, 8'h96, 8'h69, 8'hC3, 0, 0, 0, 24'hC36996);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_ccff_loader.md
Name: io_ccff_loader

Overview:
- Sequences programming of the IO-tile configuration chain (ccff_head → … → ccff_tail) across a row of IO tiles.
- Accepts configuration words over a valid/ready interface and serialises them LSB-first onto ccff_head, one bit per prog_clk.
- Holds IO_ISOL_N low (pads isolated) while the chain is unconfigured or being rewritten, and releases it only after a complete load plus a settle window.
- Sits between the bitstream source and the first IO tile's ccff_head; the last tile's ccff_tail returns to it.

Parameters:
CHAIN_LEN, 24, total configuration bits in the IO chain (≥1)
WORD_W, 8, width of cfg_data words (≥1)
ISOL_HOLD, 4, cycles IO_ISOL_N stays low before the first shift and after the last shift (≥1)

Ports:
prog_clk  input  1  programming clock; all state on rising edge
prog_reset  input  1  synchronous, active-high reset
cfg_start  input  1  single-cycle request to begin a load; honoured only in IDLE
cfg_data  input  WORD_W  configuration word; bit 0 shifted first
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts cfg_data this cycle
ccff_head  output  1  serial configuration bit into the chain
ccff_tail  input  1  serial bit returning from the chain end
IO_ISOL_N  output  1  active-low pad isolation to all IO tiles
cfg_busy  output  1  high in every state except IDLE
cfg_done  output  1  one-cycle pulse on successful load completion
cfg_err  output  1  sticky readback mismatch flag (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, ccff_head=0, IO_ISOL_N=0, cfg_ready=0, cfg_busy=0, cfg_done=0, cfg_err=0, configured flag=0, all counters 0.
- IO_ISOL_N is registered: 1 only in IDLE when configured=1; 0 at all other times.
- States:
  - IDLE: cfg_start=1 → ISOLATE; clears configured and cfg_err. cfg_valid ignored.
  - ISOLATE: counts ISOL_HOLD cycles, then → SHIFT.
  - SHIFT:
    - cfg_ready=1 only when the word register is empty; a word transfers on cfg_valid && cfg_ready.
    - The cycle after acceptance, ccff_head is driven with word bit 0, then bit 1, …, one bit per cycle; the bit counter increments per shifted bit.
    - The final word shifts only the remaining CHAIN_LEN mod WORD_W bits (or WORD_W if that is 0); its upper bits are discarded.
    - Words needed = ceil(CHAIN_LEN/WORD_W).
    - If cfg_valid is low while the register is empty, ccff_head holds its value and the counter does not advance (stall).
    - Bit counter reaches CHAIN_LEN → SETTLE, with cfg_ready=0.
  - SETTLE: ccff_head=0; counts ISOL_HOLD cycles → VERIFY if the macro is defined, else → DONE.
  - DONE: sets configured=1, pulses cfg_done for 1 cycle → IDLE. IO_ISOL_N rises 1 cycle later.
- cfg_start in any state other than IDLE is ignored.
- Counters are sized as clog2(max+1); no wrap-around occurs within a load.
- prog_reset asserted in any state: next cycle in IDLE with reset values, configured=0, IO_ISOL_N=0 (pads stay isolated until a new full load).
- Chain shifting uses prog_clk directly; the chain advances only in cycles where the loader drives a new bit.

Optional Feature:
- Macro IO_CCFF_READBACK_EN.
- Defined:
  - A CRC-8 (polynomial 0x07, init 0x00) accumulates every bit driven in SHIFT.
  - VERIFY state runs CHAIN_LEN cycles with ccff_head=ccff_tail (recirculation, chain contents preserved) and accumulates a second CRC-8 over ccff_tail.
  - Equal CRCs → DONE.
  - Mismatch → cfg_err=1 (sticky until the next cfg_start or reset), configured stays 0, → IDLE with no cfg_done, IO_ISOL_N remains 0.
- Undefined: no VERIFY state or CRC logic; cfg_err tied 0.

Test Plan:
- Reset, then hold idle 10 cycles → IO_ISOL_N=0, cfg_busy=0, ccff_head=0, cfg_ready=0.
- CHAIN_LEN=24, WORD_W=8, words 0xA5, 0x3C, 0xF0 sent back-to-back, with a 24-bit shift-register model as the chain → IO_ISOL_N=0 for the full 4+24+4 cycle span; model holds 0xF03CA5 with the first bit at the far end; cfg_done pulses once; IO_ISOL_N=1 the cycle after.
- CHAIN_LEN=20 with 3 words, last word 0xFF → exactly 20 bits shifted; bits 4..7 of the last word never appear on ccff_head.
- cfg_valid deasserted 5 cycles between word 1 and word 2 → ccff_head and the bit counter hold; final chain contents match the no-stall case.
- prog_reset pulsed mid-SHIFT after 10 bits, then a new full load → IDLE next cycle, IO_ISOL_N=0, no cfg_done; the second load completes normally.
- With IO_CCFF_READBACK_EN, the chain model flips bit 7 during SETTLE → cfg_err=1, no cfg_done, IO_ISOL_N stays 0. Repeat without corruption → cfg_err=0, cfg_done pulses.
